// File: rtl/rbcp_axil_pkg.sv
// Shared types and constants for the RBCP to AXI4-Lite bridge.
package rbcp_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD,
    ST_RD_DATA,
    ST_ACK,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [7:0] RBCP_TIMEOUT_BYTE = 8'hEE;

  function automatic bit data_width_legal(input int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/rbcp_axil_lane_steer.sv
// Byte-lane steering: write-byte replication, one-hot strobe, read-byte extraction.
module rbcp_axil_lane_steer #(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned STRB_W = DATA_WIDTH / 8,
  localparam int unsigned LANE_W = $clog2(STRB_W)
) (
  input  logic [LANE_W-1:0]     wr_lane,
  input  logic [7:0]            wr_byte,
  output logic [DATA_WIDTH-1:0] wdata_c,
  output logic [STRB_W-1:0]     wstrb_c,
  input  logic [LANE_W-1:0]     rd_lane,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [7:0]            rd_byte_c
);

  always_comb begin
    wdata_c   = {STRB_W{wr_byte}};
    wstrb_c   = STRB_W'(1) << wr_lane;
    rd_byte_c = 8'(rdata >> {rd_lane, 3'b000});
  end

endmodule

// File: rtl/rbcp_axil_bridge.sv
// SiTCP RBCP byte port to single-beat AXI4-Lite master bridge.
// Optional stalled-slave timeout with DRAIN state: define RBCP_AXIL_TIMEOUT_EN.
module rbcp_axil_bridge
  import rbcp_axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    rbcp_act,
  input  logic [31:0]             rbcp_addr,
  input  logic [7:0]              rbcp_wd,
  input  logic                    rbcp_we,
  input  logic                    rbcp_re,
  output logic                    rbcp_ack,
  output logic [7:0]              rbcp_rd,
  input  logic                    err_clr,
  output logic                    resp_err,
  output logic                    timeout_err,
  output logic                    busy,
  output logic [31:0]             m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [31:0]             m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(STRB_W);

  if (!data_width_legal(DATA_WIDTH)) begin : g_bad_width
    $error("rbcp_axil_bridge: DATA_WIDTH must be 32 or 64");
  end

  state_e                  state_q, state_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic                    ack_q, ack_d, busy_q, busy_d, resp_err_q, resp_err_d;
  logic [7:0]              rd_q, rd_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [DATA_WIDTH-1:0]   wdata_c;
  logic [STRB_W-1:0]       wstrb_c;
  logic [7:0]              rd_byte_c;
  logic                    unused_c;

`ifdef RBCP_AXIL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d, drain_q, drain_d, is_wr_q, is_wr_d;
  logic             in_flight_c;
`endif

  assign unused_c = rbcp_act ^ (TIMEOUT_CYCLES == 0);

  rbcp_axil_lane_steer #(.DATA_WIDTH(DATA_WIDTH)) u_steer (
    .wr_lane   (rbcp_addr[LANE_W-1:0]),
    .wr_byte   (rbcp_wd),
    .wdata_c   (wdata_c),
    .wstrb_c   (wstrb_c),
    .rd_lane   (lane_q),
    .rdata     (m_axi_rdata),
    .rd_byte_c (rd_byte_c)
  );

  // Next state; every valid retires on its own handshake regardless of state.
  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q & ~m_axi_awready;
    wvalid_d   = wvalid_q & ~m_axi_wready;
    arvalid_d  = arvalid_q & ~m_axi_arready;
    bready_d   = bready_q;
    rready_d   = rready_q;
    ack_d      = 1'b0;
    rd_d       = rd_q;
    resp_err_d = resp_err_q & ~err_clr;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    lane_d     = lane_q;
`ifdef RBCP_AXIL_TIMEOUT_EN
    timeout_err_d = timeout_err_q & ~err_clr;
    drain_d       = drain_q;
    is_wr_d       = is_wr_q;
    cnt_d         = '0;
    in_flight_c   = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                    (state_q == ST_RD) || (state_q == ST_RD_DATA);
`endif

    case (state_q)
      ST_IDLE: begin
        if (rbcp_we || rbcp_re) begin
          addr_d  = {rbcp_addr[31:LANE_W], LANE_W'(0)};
          lane_d  = rbcp_addr[LANE_W-1:0];
          wdata_d = wdata_c;
          wstrb_d = wstrb_c;
`ifdef RBCP_AXIL_TIMEOUT_EN
          is_wr_d = rbcp_we;
`endif
        end
        if (rbcp_we) begin
          state_d   = ST_WR;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else if (rbcp_re) begin
          state_d   = ST_RD;
          arvalid_d = 1'b1;
        end
      end
      ST_WR: begin
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          state_d  = ST_ACK;
          bready_d = 1'b0;
          ack_d    = 1'b1;
          if (m_axi_bresp != AXI_RESP_OKAY) resp_err_d = 1'b1;
        end
      end
      ST_RD: begin
        if (!arvalid_d) begin
          state_d  = ST_RD_DATA;
          rready_d = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_rvalid && rready_q) begin
          state_d  = ST_ACK;
          rready_d = 1'b0;
          ack_d    = 1'b1;
          rd_d     = rd_byte_c;
          if (m_axi_rresp != AXI_RESP_OKAY) resp_err_d = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
`ifdef RBCP_AXIL_TIMEOUT_EN
        if (drain_q) state_d = ST_DRAIN;
`endif
      end
`ifdef RBCP_AXIL_TIMEOUT_EN
      // Finish the abandoned transaction quietly; its response is discarded.
      ST_DRAIN: begin
        if (is_wr_q) begin
          if (m_axi_bvalid && bready_q) begin
            state_d  = ST_IDLE;
            bready_d = 1'b0;
            drain_d  = 1'b0;
          end else begin
            bready_d = !awvalid_d && !wvalid_d;
          end
        end else begin
          if (m_axi_rvalid && rready_q) begin
            state_d  = ST_IDLE;
            rready_d = 1'b0;
            drain_d  = 1'b0;
          end else begin
            rready_d = !arvalid_d;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef RBCP_AXIL_TIMEOUT_EN
    if (in_flight_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      if ((cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && (state_d != ST_ACK)) begin
        state_d       = ST_ACK;
        ack_d         = 1'b1;
        rd_d          = RBCP_TIMEOUT_BYTE;
        timeout_err_d = 1'b1;
        bready_d      = 1'b0;
        rready_d      = 1'b0;
        drain_d       = 1'b1;
      end
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q    <= ST_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      resp_err_q <= 1'b0;
      rd_q       <= 8'h00;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      resp_err_q <= resp_err_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      lane_q     <= lane_d;
    end
  end

`ifdef RBCP_AXIL_TIMEOUT_EN
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      drain_q       <= 1'b0;
      is_wr_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      drain_q       <= drain_d;
      is_wr_q       <= is_wr_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign rbcp_ack      = ack_q;
  assign rbcp_rd       = rd_q;
  assign resp_err      = resp_err_q;
  assign busy          = busy_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_rbcp_axil_bridge.sv
// Directed bench: 32-bit and 64-bit bridges share RBCP stimulus, each with its own slave model.
`timescale 1ns/1ps
module tb_rbcp_axil_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rbcp_act = 1'b1, rbcp_we = 1'b0, rbcp_re = 1'b0, err_clr = 1'b0;
  logic [31:0] rbcp_addr = '0;
  logic [7:0]  rbcp_wd = '0;

  // 32-bit instance
  logic        ack32, busy32, rerr32, terr32;
  logic [7:0]  rd32;
  logic [31:0] s32_awaddr, s32_araddr, s32_wdata;
  logic [31:0] s32_rdata = 32'hDDCCBBAA;
  logic [3:0]  s32_wstrb;
  logic [2:0]  s32_awprot, s32_arprot;
  logic [1:0]  s32_rresp = 2'b00;
  logic [1:0]  s32_bresp;
  logic        s32_awvalid, s32_awready, s32_wvalid, s32_wready, s32_bvalid, s32_bready;
  logic        s32_arvalid, s32_arready, s32_rvalid, s32_rready;

  // 64-bit instance
  logic        ack64, busy64, rerr64, terr64;
  logic [7:0]  rd64;
  logic [31:0] s64_awaddr, s64_araddr;
  logic [63:0] s64_wdata, s64_rdata;
  logic [7:0]  s64_wstrb;
  logic [2:0]  s64_awprot, s64_arprot;
  logic [1:0]  s64_bresp, s64_rresp;
  logic        s64_awvalid, s64_awready, s64_wvalid, s64_wready, s64_bvalid, s64_bready;
  logic        s64_arvalid, s64_arready, s64_rvalid, s64_rready;

  rbcp_axil_bridge #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut32 (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .rbcp_act(rbcp_act), .rbcp_addr(rbcp_addr),
    .rbcp_wd(rbcp_wd), .rbcp_we(rbcp_we), .rbcp_re(rbcp_re), .rbcp_ack(ack32), .rbcp_rd(rd32),
    .err_clr(err_clr), .resp_err(rerr32), .timeout_err(terr32), .busy(busy32),
    .m_axi_awaddr(s32_awaddr), .m_axi_awprot(s32_awprot), .m_axi_awvalid(s32_awvalid),
    .m_axi_awready(s32_awready), .m_axi_wdata(s32_wdata), .m_axi_wstrb(s32_wstrb),
    .m_axi_wvalid(s32_wvalid), .m_axi_wready(s32_wready), .m_axi_bresp(s32_bresp),
    .m_axi_bvalid(s32_bvalid), .m_axi_bready(s32_bready), .m_axi_araddr(s32_araddr),
    .m_axi_arprot(s32_arprot), .m_axi_arvalid(s32_arvalid), .m_axi_arready(s32_arready),
    .m_axi_rdata(s32_rdata), .m_axi_rresp(s32_rresp), .m_axi_rvalid(s32_rvalid),
    .m_axi_rready(s32_rready)
  );

  rbcp_axil_bridge #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(16)) dut64 (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .rbcp_act(rbcp_act), .rbcp_addr(rbcp_addr),
    .rbcp_wd(rbcp_wd), .rbcp_we(rbcp_we), .rbcp_re(rbcp_re), .rbcp_ack(ack64), .rbcp_rd(rd64),
    .err_clr(err_clr), .resp_err(rerr64), .timeout_err(terr64), .busy(busy64),
    .m_axi_awaddr(s64_awaddr), .m_axi_awprot(s64_awprot), .m_axi_awvalid(s64_awvalid),
    .m_axi_awready(s64_awready), .m_axi_wdata(s64_wdata), .m_axi_wstrb(s64_wstrb),
    .m_axi_wvalid(s64_wvalid), .m_axi_wready(s64_wready), .m_axi_bresp(s64_bresp),
    .m_axi_bvalid(s64_bvalid), .m_axi_bready(s64_bready), .m_axi_araddr(s64_araddr),
    .m_axi_arprot(s64_arprot), .m_axi_arvalid(s64_arvalid), .m_axi_arready(s64_arready),
    .m_axi_rdata(s64_rdata), .m_axi_rresp(s64_rresp), .m_axi_rvalid(s64_rvalid),
    .m_axi_rready(s64_rready)
  );

  // Slave models: 32-bit one has a programmable AW delay and B/AR stalls.
  int          aw_delay = 0;
  int          aw_wait;
  bit          ar_block = 1'b0, b_block = 1'b0;
  logic        aw_got, w_got;
  logic [31:0] cap32_awaddr, cap32_araddr, cap32_wdata;
  logic [3:0]  cap32_wstrb;
  logic [31:0] cap64_awaddr, cap64_araddr;
  logic [63:0] cap64_wdata;
  logic [7:0]  cap64_wstrb;

  assign s32_awready = s32_awvalid && (aw_wait >= aw_delay);
  assign s32_wready  = s32_wvalid;
  assign s32_arready = s32_arvalid && !ar_block;
  assign s32_bresp   = 2'b00;
  assign s64_awready = s64_awvalid;
  assign s64_wready  = s64_wvalid;
  assign s64_arready = s64_arvalid && !ar_block;
  assign s64_bresp   = 2'b00;
  assign s64_rresp   = 2'b00;
  assign s64_rdata   = 64'h8877665544332211;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; s32_bvalid <= 1'b0; s32_rvalid <= 1'b0;
    end else begin
      if (s32_awvalid && s32_awready) begin
        aw_wait <= 0; aw_got <= 1'b1; cap32_awaddr <= s32_awaddr;
      end else if (s32_awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (s32_wvalid && s32_wready) begin
        w_got <= 1'b1; cap32_wdata <= s32_wdata; cap32_wstrb <= s32_wstrb;
      end
      if (s32_bvalid && s32_bready) s32_bvalid <= 1'b0;
      if (!s32_bvalid && !b_block && (aw_got || (s32_awvalid && s32_awready)) &&
          (w_got || (s32_wvalid && s32_wready))) begin
        s32_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (s32_rvalid && s32_rready) s32_rvalid <= 1'b0;
      if (s32_arvalid && s32_arready) begin
        s32_rvalid <= 1'b1; cap32_araddr <= s32_araddr;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      s64_bvalid <= 1'b0; s64_rvalid <= 1'b0;
    end else begin
      if (s64_bvalid && s64_bready) s64_bvalid <= 1'b0;
      if (s64_awvalid && s64_wvalid) begin
        s64_bvalid <= 1'b1; cap64_awaddr <= s64_awaddr; cap64_wdata <= s64_wdata;
        cap64_wstrb <= s64_wstrb;
      end
      if (s64_rvalid && s64_rready) s64_rvalid <= 1'b0;
      if (s64_arvalid && s64_arready) begin
        s64_rvalid <= 1'b1; cap64_araddr <= s64_araddr;
      end
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  rd;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_chk = 0, n_pass = 0;
  int lat32, lat64, acks32, awc, wc, arc;
  logic [7:0] obs_rd32, obs_rd64;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One RBCP request; cycle c of the loop is cycle N+c of the transaction.
  task automatic run_op(input bit wr, input bit rd, input logic [31:0] a, input logic [7:0] d,
                        input int clr_at, input int re_at, input int rel_at);
    @(negedge clk);
    rbcp_addr = a; rbcp_wd = d; rbcp_we = wr; rbcp_re = rd;
    lat32 = -1; lat64 = -1; acks32 = 0; awc = 0; wc = 0; arc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin rbcp_addr = 32'hDEADBEEF; rbcp_wd = 8'h3C; end
      rbcp_we = 1'b0;
      rbcp_re = (c == re_at);
      err_clr = (c == clr_at);
      if (c == rel_at) ar_block = 1'b0;
      awc += int'(s32_awvalid); wc += int'(s32_wvalid); arc += int'(s32_arvalid);
      if (ack32) begin acks32++; if (lat32 < 0) begin lat32 = c; obs_rd32 = rd32; end end
      if (ack64 && lat64 < 0) begin lat64 = c; obs_rd64 = rd64; end
      if (lat32 >= 0 && lat64 >= 0 && !busy32 && !busy64) break;
    end
    rbcp_re = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs32", {busy32, ack32, rd32, rerr32, terr32, s32_awvalid, s32_wvalid,
        s32_bready, s32_arvalid, s32_rready, s32_awprot, s32_arprot}, '0);
    chk("reset_outs64", {busy64, ack64, rd64, rerr64, s64_awvalid, s64_arvalid, s64_bready,
        s64_rready}, '0);
    rst_n = 1'b1;

    // Write 0xA5 to 0x1006 with zero-wait slaves.
    sb.push_back('{"wr32", 32'h0000_1004, 64'hA5A5A5A5, 8'h04, 8'h00, 3});
    sb.push_back('{"wr64", 32'h0000_1000, 64'hA5A5A5A5A5A5A5A5, 8'h40, 8'h00, 3});
    run_op(1'b1, 1'b0, 32'h0000_1006, 8'hA5, 0, 0, 0);
    e = sb.pop_front();
    chk({e.tag, "_awaddr"}, 64'(cap32_awaddr), 64'(e.addr));
    chk({e.tag, "_wdata"}, 64'(cap32_wdata), e.data);
    chk({e.tag, "_wstrb"}, 64'(cap32_wstrb), 64'(e.strb));
    chk({e.tag, "_lat"}, 64'(lat32), 64'(e.lat));
    e = sb.pop_front();
    chk({e.tag, "_awaddr"}, 64'(cap64_awaddr), 64'(e.addr));
    chk({e.tag, "_wdata"}, cap64_wdata, e.data);
    chk({e.tag, "_wstrb"}, 64'(cap64_wstrb), 64'(e.strb));

    // Read 0x2003.
    sb.push_back('{"rd32", 32'h0000_2000, 64'h0, 8'h00, 8'hDD, 3});
    sb.push_back('{"rd64", 32'h0000_2000, 64'h0, 8'h00, 8'h44, 3});
    run_op(1'b0, 1'b1, 32'h0000_2003, 8'h00, 0, 0, 0);
    e = sb.pop_front();
    chk({e.tag, "_araddr"}, 64'(cap32_araddr), 64'(e.addr));
    chk({e.tag, "_byte"}, 64'(obs_rd32), 64'(e.rd));
    chk({e.tag, "_lat"}, 64'(lat32), 64'(e.lat));
    e = sb.pop_front();
    chk({e.tag, "_araddr"}, 64'(cap64_araddr), 64'(e.addr));
    chk({e.tag, "_byte"}, 64'(obs_rd64), 64'(e.rd));
    chk({e.tag, "_lat"}, 64'(lat64), 64'(e.lat));

    // AW stalled 3 cycles, rbcp_act dropped, stray read request while busy.
    aw_delay = 3; rbcp_act = 1'b0;
    sb.push_back('{"wr_awstall", 32'h0000_0000, 64'h30303030, 8'h08, 8'hDD, 6});
    run_op(1'b1, 1'b0, 32'h0000_0003, 8'h30, 0, 2, 0);
    aw_delay = 0; rbcp_act = 1'b1;
    e = sb.pop_front();
    chk({e.tag, "_lat"}, 64'(lat32), 64'(e.lat));
    chk({e.tag, "_awvalid_cycles"}, 64'(awc), 64'd4);
    chk({e.tag, "_wvalid_cycles"}, 64'(wc), 64'd1);
    chk({e.tag, "_no_read"}, 64'(arc), 64'd0);
    chk({e.tag, "_wdata"}, 64'(cap32_wdata), e.data);
    chk({e.tag, "_wstrb"}, 64'(cap32_wstrb), 64'(e.strb));
    chk({e.tag, "_rd_held"}, 64'(rd32), 64'(e.rd));

    // Simultaneous we/re: write wins.
    run_op(1'b1, 1'b1, 32'h0000_0040, 8'h5A, 0, 0, 0);
    chk("we_re_awaddr", 64'(cap32_awaddr), 64'h40);
    chk("we_re_wstrb", 64'(cap32_wstrb), 64'h1);
    chk("we_re_no_read", 64'(arc), 64'd0);

    // Error response: sticky flag, byte unaltered, clear, then set-beats-clear.
    s32_rresp = 2'b10;
    run_op(1'b0, 1'b1, 32'h0000_1001, 8'h00, 0, 0, 0);
    chk("rresp_err_acks", 64'(acks32), 64'd1);
    chk("rresp_err_byte", 64'(obs_rd32), 64'hBB);
    chk("rresp_err_flag", 64'(rerr32), 64'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_clr_clears", 64'(rerr32), 64'd0);
    run_op(1'b0, 1'b1, 32'h0000_1001, 8'h00, 2, 0, 0);
    chk("err_set_wins", 64'(rerr32), 64'd1);
    s32_rresp = 2'b00;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_clr_again", 64'(rerr32), 64'd0);

    // Reset while waiting in WR_RESP.
    b_block = 1'b1;
    @(negedge clk); rbcp_addr = 32'h0000_1008; rbcp_wd = 8'h11; rbcp_we = 1'b1;
    @(negedge clk); rbcp_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("wr_resp_wait", {63'(0), s32_bready & busy32}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_txn", {s32_bready, busy32, s32_awvalid, ack32}, 4'b0000);
    rst_n = 1'b1; b_block = 1'b0;
    run_op(1'b1, 1'b0, 32'h0000_100A, 8'h77, 0, 0, 0);
    chk("post_reset_lat", 64'(lat32), 64'd3);
    chk("post_reset_awaddr", 64'(cap32_awaddr), 64'h1008);
    chk("post_reset_wdata", 64'(cap32_wdata), 64'h77777777);
    chk("post_reset_wstrb", 64'(cap32_wstrb), 64'h4);

`ifdef RBCP_AXIL_TIMEOUT_EN
    // Stalled AR: timeout ack at N+17, read during DRAIN ignored, drain on release.
    ar_block = 1'b1;
    run_op(1'b0, 1'b1, 32'h0000_3000, 8'h00, 0, 20, 30);
    chk("timeout_lat", 64'(lat32), 64'd17);
    chk("timeout_byte", 64'(obs_rd32), 64'hEE);
    chk("timeout_flag", 64'(terr32), 64'd1);
    chk("timeout_acks", 64'(acks32), 64'd1);
    chk("timeout_drained", 64'(busy32), 64'd0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("timeout_clr", 64'(terr32), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rbcp_axil_bridge.md
# rbcp_axil_bridge

Parametrised bridge from the SiTCP RBCP byte-access port to a single-beat AXI4-Lite master of configurable data width. Each RBCP byte read or write becomes exactly one aligned AXI transaction with byte-lane strobes and byte extraction. It also reports sticky response errors and, optionally, times out stalled slaves. It sits between the SiTCP core and the AXI-Lite interconnect and replaces the 8-to-32 bridge/adapter pair at the top level.

## Interface
Parameters:
- DATA_WIDTH, 32: AXI data width. Legal values are 32 and 64; any other value is an elaboration error.
- TIMEOUT_CYCLES, 1024: cycles allowed from issue to completion. Used only with the timeout feature compiled in.

Ports (one clock; reset is synchronous and active-low):
- m_axi_aclk  in  1  sole clock; the SiTCP side runs on the same clock.
- m_axi_aresetn  in  1  synchronous active-low reset.
- rbcp_act  in  1  RBCP active; informational only.
- rbcp_addr  in  32  byte address.
- rbcp_wd  in  8  write byte.
- rbcp_we / rbcp_re  in  1  single-cycle write / read request.
- rbcp_ack  out  1  single-cycle completion pulse.
- rbcp_rd  out  8  read byte, valid while rbcp_ack=1.
- err_clr  in  1  clears the sticky error flags.
- resp_err  out  1  sticky: a BRESP or RRESP other than OKAY was received.
- timeout_err  out  1  sticky timeout flag.
- busy  out  1  high in every state except IDLE.
- m_axi_aw*, w*, b*, ar*, r*: AXI4-Lite master. Data is DATA_WIDTH bits, strobe is DATA_WIDTH/8 bits, addresses are 32 bits, awprot/arprot are constant 3'b000.

## Operation
- L = log2(DATA_WIDTH/8). Aligned address = {rbcp_addr[31:L], L'b0}. Lane = rbcp_addr[L-1:0].
- Write: wdata = rbcp_wd replicated into every byte lane; wstrb is one-hot at the lane.
- Read: rbcp_rd = rdata[8*lane +: 8], captured on the R handshake.
- State machine:
  - IDLE: rbcp_we → WR; rbcp_re → RD.
  - WR: awvalid and wvalid are raised together. Each drops independently after its own handshake. When both are done → WR_RESP.
  - WR_RESP: bready=1. On the B handshake → ACK.
  - RD: arvalid=1. On the AR handshake → RD_DATA.
  - RD_DATA: rready=1. On the R handshake → ACK.
  - ACK: rbcp_ack=1 for one cycle → IDLE.
- Address, lane, data and operation are registered in IDLE. rbcp_addr and rbcp_wd are don't-care afterwards.
- If rbcp_we and rbcp_re are high in the same cycle, the write is taken and the read is ignored.
- rbcp_we and rbcp_re are ignored outside IDLE.
- Deassertion of rbcp_act mid-transaction has no effect: the transaction completes and ack is still pulsed.
- Non-OKAY response: resp_err is set and ack is still given. For a read, the byte is returned unaltered.
- err_clr clears both sticky flags. If err_clr and a new error occur in the same cycle, the set wins.
- Output values under reset: all valid and ready outputs 0, rbcp_ack 0, rbcp_rd 8'h00, resp_err 0, timeout_err 0, busy 0, state IDLE.
- Reset mid-transaction returns to IDLE immediately. The outstanding AXI transaction is abandoned, because the slave shares the same reset.

## Timing
- Cycle N: request sampled in IDLE.
- Cycle N+1: awvalid/wvalid (or arvalid) asserted.
- With a zero-wait slave (handshake at N+1, response valid at N+2), rbcp_ack is high at N+3. Minimum latency is 3 cycles.
- Each extra wait cycle on any channel adds exactly one cycle.
- rbcp_rd is registered. It is valid during the ack cycle and holds its value until the next read's ack.
- AXI rules:
  - Valid is never dropped before its ready.
  - Address, data and strobe outputs are stable while their valid is high.
  - bready and rready are asserted only in their respective wait states.

## Configuration
- RBCP_AXIL_TIMEOUT_EN defined:
  - A counter starts when WR or RD is entered.
  - If the transaction has not completed after TIMEOUT_CYCLES cycles: go to ACK with rbcp_rd=8'hEE and set timeout_err, then enter DRAIN.
  - DRAIN: pending valids stay high until their handshakes, then the response is accepted and discarded → IDLE.
  - New RBCP requests are ignored while in DRAIN.
- RBCP_AXIL_TIMEOUT_EN undefined:
  - No counter and no DRAIN state; the bridge waits indefinitely.
  - timeout_err is tied to 0.

## Structure
- Package rbcp_axil_pkg holds:
  - the state enum;
  - AXI_RESP_OKAY = 2'b00;
  - RBCP_TIMEOUT_BYTE = 8'hEE;
  - the width-legality check function.
- Sub-module rbcp_axil_lane_steer, parametrised by DATA_WIDTH: byte replication, one-hot strobe generation, and read-byte extraction.

## Test plan
- DATA_WIDTH=32, write 8'hA5 to 0x0000_1006 with a zero-wait slave → awaddr=0x0000_1004, wdata=0xA5A5A5A5, wstrb=4'b0100, rbcp_ack at N+3.
- DATA_WIDTH=64, read 0x0000_2003 where the slave returns 0x8877665544332211 → araddr=0x0000_2000, rbcp_rd=8'h44.
- awready delayed 3 cycles with wready immediate → wvalid drops after 1 cycle, awvalid is held 4 cycles, rbcp_ack at N+6.
- Slave returns RRESP=2'b10 → rbcp_ack is pulsed and resp_err=1 until err_clr; an err_clr in the same cycle as a new error leaves resp_err=1.
- With RBCP_AXIL_TIMEOUT_EN and TIMEOUT_CYCLES=16, arready is never given for 30 cycles → at N+17 rbcp_ack=1, rbcp_rd=8'hEE, timeout_err=1. An rbcp_re pulse during DRAIN is ignored. After arready and the R handshake, busy=0.
- Reset asserted in WR_RESP → next cycle: bready=0, busy=0, state IDLE. The next write completes normally.
